// File: rtl/turbo_pkg.sv
// Shared turbo-decoder helpers: default sizing plus the saturating and
// round-toward-zero halving arithmetic used by the gamma, extrinsic and
// alpha/beta units. Helpers operate on 64-bit signed values; callers
// sign-extend in and truncate out to their own widths.
package turbo_pkg;

  localparam int W_DEF         = 16;
  localparam int FRAME_LEN_DEF = 6144;
  localparam int CNT_W_DEF     = 13;

  // Halve, rounding toward zero: -3 -> -1, 3 -> 1.
  function automatic logic signed [63:0] half_rtz(input logic signed [63:0] x);
    logic signed [63:0] r;
    r = x >>> 1;
    if (x[63] && x[0]) r = r + 64'sd1;
    return r;
  endfunction

  // Clamp to the range of a w-bit two's complement number.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/gamma_branch_metric_pipe_if.sv
// Beat-level bundle for the gamma unit: LLR input stream with its
// per-beat controls, and the branch-metric output stream.
interface gamma_branch_metric_pipe_if import turbo_pkg::*; #(
  parameter int W = W_DEF
);
  logic                frame_clr;
  logic                la_en;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] systematic;
  logic signed [W-1:0] yparity;
  logic signed [W-1:0] la;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] m11;
  logic signed [W-1:0] m10;
  logic signed [W-1:0] m00;
  logic signed [W-1:0] m01;
  logic                out_last;

  modport master (
    output frame_clr, la_en, in_valid, systematic, yparity, la, out_ready,
    input  in_ready, out_valid, m11, m10, m00, m01, out_last
  );

  modport slave (
    input  frame_clr, la_en, in_valid, systematic, yparity, la, out_ready,
    output in_ready, out_valid, m11, m10, m00, m01, out_last
  );
endinterface

// File: rtl/gamma_branch_metric_pipe_round_sat.sv
// Combinational halve-and-saturate of a (W+2)-bit metric sum down to W bits.
module gamma_round_sat import turbo_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic signed [W+1:0] x,
  output logic signed [W-1:0] m
);

  assign m = W'(sat_w(half_rtz(64'(x)), W));

endmodule

// File: rtl/gamma_branch_metric_pipe.sv
// Two-stage branch-metric (gamma) pipeline for the max-log-MAP SISO.
// Stage 1 forms sys+la+par and sys+la-par at W+2 bits; stage 2 halves,
// saturates and derives the negated metrics. A single global enable
// stalls both stages under backpressure; bubbles are not collapsed.
module gamma_branch_metric_pipe import turbo_pkg::*; #(
  parameter int W         = W_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input logic clk,
  input logic rst,
  gamma_branch_metric_pipe_if.slave bus
);

  logic             adv;
  logic             xfer;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] step;
  logic             step_last;

  logic signed [W+1:0] sys_e;
  logic signed [W+1:0] par_e;
  logic signed [W+1:0] la_e;

  logic                s1_valid;
  logic signed [W+1:0] s1_s;
  logic signed [W+1:0] s1_d;
  logic                s1_last;

  logic signed [W-1:0] h_s;
  logic signed [W-1:0] h_d;
  logic signed [W-1:0] n_s;
  logic signed [W-1:0] n_d;

  assign adv         = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  assign xfer        = bus.in_valid && adv;

  // frame_clr makes the coinciding beat step 0, so it overrides the count here.
  always_comb begin
    step      = bus.frame_clr ? '0 : cnt;
    step_last = (step == CNT_W'(FRAME_LEN - 1));
    sys_e     = {{2{bus.systematic[W-1]}}, bus.systematic};
    par_e     = {{2{bus.yparity[W-1]}}, bus.yparity};
    la_e      = bus.la_en ? {{2{bus.la[W-1]}}, bus.la} : '0;
  end

  // Frame step counter: advances per accepted beat, wraps after the last step.
  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (xfer)          cnt <= step_last ? '0 : step + CNT_W'(1);
    else if (bus.frame_clr) cnt <= '0;
  end

  // Stage 1: widened sum/difference and the frame-last tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_s     <= '0;
      s1_d     <= '0;
      s1_last  <= 1'b0;
    end else if (adv) begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_s    <= sys_e + la_e + par_e;
        s1_d    <= sys_e + la_e - par_e;
        s1_last <= step_last;
      end
    end
  end

  gamma_round_sat #(.W(W)) u_rs_s (.x(s1_s), .m(h_s));
  gamma_round_sat #(.W(W)) u_rs_d (.x(s1_d), .m(h_d));

  assign n_s = W'(sat_w(-64'(h_s), W));
  assign n_d = W'(sat_w(-64'(h_d), W));

  // Stage 2: registered metrics; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.m11       <= '0;
      bus.m10       <= '0;
      bus.m00       <= '0;
      bus.m01       <= '0;
      bus.out_last  <= 1'b0;
    end else if (adv) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.m11      <= h_s;
        bus.m10      <= h_d;
        bus.m00      <= n_s;
        bus.m01      <= n_d;
        bus.out_last <= s1_last;
      end
    end
  end

endmodule

// File: tb/tb_gamma_branch_metric_pipe.sv
// Scoreboard bench for gamma_branch_metric_pipe (W=16, FRAME_LEN=4).
module tb_gamma_branch_metric_pipe;

  logic clk;
  logic rst;

  gamma_branch_metric_pipe_if #(.W(16)) bus ();

  gamma_branch_metric_pipe #(.W(16), .FRAME_LEN(4), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int m11; int m10; int m00; int m01; int last;
  } exp_t;

  typedef struct {
    bit lae; int sys; int par; int la; int e11; int e10; int e00; int e01;
  } vec_t;

  exp_t q[$];
  vec_t vt[8];
  int   tests = 0;
  int   fails = 0;
  int   bc = 0;          // bench frame-step model
  int   ready_mode = 0;  // 0: always ready, 1: 1,0,0 pattern, 2: never ready

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Consumer readiness pattern.
  initial begin
    int k;
    k = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ((k % 3) == 0);
        default: bus.out_ready = 1'b0;
      endcase
      k++;
    end
  end

  // Monitor: pops expectations on each output transfer and checks stall behaviour.
  initial begin
    bit   stall_prev;
    exp_t held;
    exp_t e;
    stall_prev = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stall_prev = 0;
        continue;
      end
      if (stall_prev && bus.out_valid) begin
        chk("stall_hold_m11", int'(bus.m11), held.m11);
        chk("stall_hold_m01", int'(bus.m01), held.m01);
        chk("stall_hold_last", int'(bus.out_last), held.last);
      end
      if (bus.out_valid && !bus.out_ready)
        chk("in_ready_during_stall", int'(bus.in_ready), 0);
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat_count", 1, 0);
        end else begin
          e = q.pop_front();
          chk("m11", int'(bus.m11), e.m11);
          chk("m10", int'(bus.m10), e.m10);
          chk("m00", int'(bus.m00), e.m00);
          chk("m01", int'(bus.m01), e.m01);
          chk("out_last", int'(bus.out_last), e.last);
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held.m11  = int'(bus.m11);
      held.m10  = int'(bus.m10);
      held.m00  = int'(bus.m00);
      held.m01  = int'(bus.m01);
      held.last = int'(bus.out_last);
    end
  end

  // Offer one beat until accepted; exp_last < 0 means use the frame-step model.
  task automatic send(input bit clr, input vec_t v, input int exp_last, input bit push);
    bit   acc;
    int   step;
    exp_t e;
    @(negedge clk);
    bus.frame_clr  = clr;
    bus.la_en      = v.lae;
    bus.systematic = 16'(v.sys);
    bus.yparity    = 16'(v.par);
    bus.la         = 16'(v.la);
    bus.in_valid   = 1'b1;
    acc = 0;
    for (int i = 0; i < 50 && !acc; i++) begin
      #1 acc = bus.in_ready;
      @(posedge clk);
      if (!acc) @(negedge clk);
    end
    if (!acc) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    step = clr ? 0 : bc;
    bc   = (step == 3) ? 0 : step + 1;
    e.m11 = v.e11; e.m10 = v.e10; e.m00 = v.e00; e.m01 = v.e01;
    e.last = (exp_last < 0) ? int'(step == 3) : exp_last;
    if (push) q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.frame_clr = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    chk("drain_queue_empty", q.size(), 0);
  endtask

  initial begin
    //          lae  sys     par     la      m11     m10     m00     m01
    vt[0] = '{0,   100,    50,     999,    75,     25,    -75,    -25};
    vt[1] = '{0,    -3,     0,       0,    -1,     -1,      1,      1};
    vt[2] = '{0,     3,     0,       0,     1,      1,     -1,     -1};
    vt[3] = '{1,  32767, 32767,  32767, 32767,  16383, -32767, -16383};
    vt[4] = '{1, -32768, -32768, -32768, -32768, -16384,  32767,  16384};
    vt[5] = '{1,    10,     7,      -4,     6,      0,     -6,      0};
    vt[6] = '{0,    -7,     2,     100,    -2,     -4,      2,      4};
    vt[7] = '{0, -32768, 32767,     55,     0, -32767,      0,  32767};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.frame_clr = 1'b0; bus.la_en = 1'b0;
    bus.systematic = '0; bus.yparity = '0; bus.la = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #3;
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_m11", int'(bus.m11), 0);
    chk("reset_m10", int'(bus.m10), 0);
    chk("reset_m00", int'(bus.m00), 0);
    chk("reset_m01", int'(bus.m01), 0);
    chk("reset_out_last", int'(bus.out_last), 0);
    chk("reset_in_ready", int'(bus.in_ready), 1);

    // Arithmetic vectors at full throughput.
    ready_mode = 0;
    for (int i = 0; i < 8; i++) send(i == 0, vt[i], -1, 1);
    idle();
    drain();

    // Same vectors under backpressure.
    ready_mode = 1;
    for (int i = 0; i < 8; i++) send(i == 0, vt[i], -1, 1);
    idle();
    drain();

    // Frame tagging: 10 beats, last on beats 3 and 7.
    ready_mode = 0;
    for (int i = 0; i < 10; i++) send(i == 0, vt[i % 8], (i == 3 || i == 7) ? 1 : 0, 1);
    idle();
    drain();

    // frame_clr on beat 5 restarts the frame: last on beats 3 and 8.
    for (int i = 0; i < 10; i++) send(i == 0 || i == 5, vt[i % 8], (i == 3 || i == 8) ? 1 : 0, 1);
    idle();
    drain();

    // Reset with both stages full and the output stalled.
    ready_mode = 2;
    send(1, vt[3], -1, 0);
    send(0, vt[4], -1, 0);
    idle();
    @(negedge clk);
    chk("prefill_stalled_valid", int'(bus.out_valid), 1);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    #3;
    chk("midreset_out_valid", int'(bus.out_valid), 0);
    chk("midreset_m11", int'(bus.m11), 0);
    rst = 1'b0;
    bc = 0;
    ready_mode = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #3;
      chk("no_stale_beat", int'(bus.out_valid), 0);
    end
    // First beats after reset start at step 0.
    for (int i = 0; i < 4; i++) send(0, vt[i], (i == 3) ? 1 : 0, 1);
    idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
